// File: rtl/fb_write_stage_if.sv
// Pixel-in / framebuffer-write bundle for fb_write_stage.
// Combinational signal grouping only, so it adds no latency.
// Only the memory side has backpressure (mem_ready); the pixel side has none.
interface fb_write_stage_if #(
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 16
);
    logic                          frame_start;
    logic [7:0]                    R;
    logic [7:0]                    G;
    logic [7:0]                    B;
    logic                          valid_pix;
    logic [ADDR_W-1:0]             mem_addr;
    logic [15:0]                   mem_data;
    logic                          mem_we;
    logic                          mem_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          overflow;
    logic                          frame_done;

    // The write stage is the master of the framebuffer port.
    modport master (
        input  frame_start, R, G, B, valid_pix, mem_ready,
        output mem_addr, mem_data, mem_we, fifo_level, overflow, frame_done
    );

    modport slave (
        output frame_start, R, G, B, valid_pix, mem_ready,
        input  mem_addr, mem_data, mem_we, fifo_level, overflow, frame_done
    );
endinterface

// File: rtl/fb_write_stage.sv
// RGB888 -> RGB565 converter with raster addressing and an FWFT FIFO into the framebuffer port.
// Latency: a pixel pushed into an empty FIFO appears on mem_* one cycle after its input edge.
// Backpressure: mem_ready stalls the FIFO head; when the FIFO is full, pixels are dropped and overflow is set.
module fb_write_stage #(
    parameter int H_RES      = 320,
    parameter int V_RES      = 240,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    fb_write_stage_if.master  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int FRAME = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME - 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       dat;
    } entry_t;

    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic [ADDR_W-1:0]  pix_addr;
    entry_t             last_q;
    logic               overflow_q;
    logic               frame_done_q;

    logic               empty;
    logic               full;
    logic               pop;
    logic               push;
    entry_t             head;
    entry_t             in_entry;
    logic [PTR_W-1:0]   wr_slot;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign pop   = !empty && bus.mem_ready;
    // A flush empties the FIFO, so the same-cycle pixel always fits.
    assign push  = bus.valid_pix && (bus.frame_start || !full || pop);
    assign head  = fifo_mem[rd_ptr];

    assign in_entry.addr = bus.frame_start ? '0 : pix_addr;
    assign in_entry.dat  = {bus.R[7:3], bus.G[7:2], bus.B[7:3]};
    assign wr_slot       = bus.frame_start ? '0 : wr_ptr;

    // When empty, keep presenting the last head so the port does not glitch.
    assign bus.mem_we     = !empty;
    assign bus.mem_addr   = empty ? last_q.addr : head.addr;
    assign bus.mem_data   = empty ? last_q.dat  : head.dat;
    assign bus.fifo_level = level;
    assign bus.overflow   = overflow_q;
    assign bus.frame_done = frame_done_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_slot] <= in_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            pix_addr     <= '0;
            last_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (!empty) begin
                last_q <= head;
            end
            if (bus.frame_start) begin
                wr_ptr       <= PTR_W'(bus.valid_pix);
                rd_ptr       <= '0;
                level        <= LVL_W'(bus.valid_pix);
                pix_addr     <= ADDR_W'(bus.valid_pix);
                overflow_q   <= 1'b0;
                frame_done_q <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   level <= level + LVL_W'(1);
                    2'b01:   level <= level - LVL_W'(1);
                    default: level <= level;
                endcase
                if (bus.valid_pix && full && !pop) begin
                    overflow_q <= 1'b1;
                end
                frame_done_q <= pop && (head.addr == LAST_ADDR);
                // The address advances even for dropped pixels so later ones stay aligned.
                if (bus.valid_pix) begin
                    pix_addr <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + ADDR_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_write_stage.sv
// Randomized bench for fb_write_stage against a queue-based model of the FIFO and framebuffer.
module tb_fb_write_stage;
    localparam int H  = 4;
    localparam int V  = 8;
    localparam int D  = 16;
    localparam int AW = 5;
    localparam int FRAME = H * V;

    logic clk;
    logic rst_n;

    fb_write_stage_if #(.ADDR_W(AW), .FIFO_DEPTH(D)) bus ();

    fb_write_stage #(
        .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .ADDR_W(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int dat;
    } ent_t;

    ent_t q[$];
    int   m_pa;
    int   m_ov;
    int   m_fd;
    int   m_last_a;
    int   m_last_d;

    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_pa     = 0;
        m_ov     = 0;
        m_fd     = 0;
        m_last_a = 0;
        m_last_d = 0;
    endfunction

    task automatic check_outputs();
        int we;
        we = (q.size() != 0) ? 1 : 0;
        check("mem_we", int'(bus.mem_we), we);
        check("mem_addr", int'(bus.mem_addr), we ? q[0].addr : m_last_a);
        check("mem_data", int'(bus.mem_data), we ? q[0].dat : m_last_d);
        check("fifo_level", int'(bus.fifo_level), q.size());
        check("overflow", int'(bus.overflow), m_ov);
        check("frame_done", int'(bus.frame_done), m_fd);
    endtask

    function automatic void model_step(input int fs, input int v, input int rdy,
                                       input int r, input int g, input int b);
        int  d565;
        bit  pop;
        d565 = ((r / 8) * 2048) + ((g / 4) * 32) + (b / 8);
        pop  = (q.size() != 0) && (rdy != 0);
        if (q.size() != 0) begin
            m_last_a = q[0].addr;
            m_last_d = q[0].dat;
        end
        if (fs != 0) begin
            q.delete();
            m_ov = 0;
            m_fd = 0;
            if (v != 0) begin
                q.push_back('{0, d565});
                m_pa = 1;
            end else begin
                m_pa = 0;
            end
        end else begin
            m_fd = (pop && q[0].addr == FRAME - 1) ? 1 : 0;
            if (pop) void'(q.pop_front());
            if (v != 0) begin
                if (q.size() < D) q.push_back('{m_pa, d565});
                else m_ov = 1;
                m_pa = (m_pa + 1) % FRAME;
            end
        end
    endfunction

    // Drive one cycle of inputs, check the state left by the previous edge, then clock.
    task automatic cycle(input int fs, input int v, input int rdy,
                         input int r, input int g, input int b);
        bus.frame_start = fs[0];
        bus.valid_pix   = v[0];
        bus.mem_ready   = rdy[0];
        bus.R           = r[7:0];
        bus.G           = g[7:0];
        bus.B           = b[7:0];
        @(negedge clk);
        check_outputs();
        model_step(fs, v, rdy, r, g, b);
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_pix(input int fs, input int v, input int rdy);
        cycle(fs, v, rdy, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        bus.frame_start = 1'b0;
        bus.valid_pix   = 1'b0;
        bus.mem_ready   = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_mem_we", int'(bus.mem_we), 0);
        check("rst_mem_addr", int'(bus.mem_addr), 0);
        check("rst_mem_data", int'(bus.mem_data), 0);
        check("rst_level", int'(bus.fifo_level), 0);
        check("rst_overflow", int'(bus.overflow), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int rdy_pct;
        n_tests = 0;
        n_fail  = 0;
        bus.R = 8'h00;
        bus.G = 8'h00;
        bus.B = 8'h00;
        do_reset();

        // Single pixel: 0xFF,0x80,0x08 -> 0xFC01 at address 0.
        cycle(0, 1, 1, 8'hFF, 8'h80, 8'h08);
        check("single_we", int'(bus.mem_we), 1);
        check("single_addr", int'(bus.mem_addr), 0);
        check("single_data", int'(bus.mem_data), 16'hFC01);
        for (int i = 0; i < 3; i++) rnd_pix(0, 0, 1);

        // Quad stream stalled for 6 cycles, then drained.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) rnd_pix(0, 1, 0);
        for (int i = 0; i < 2; i++) rnd_pix(0, 0, 0);
        check("quad_level", int'(bus.fifo_level), 4);
        for (int i = 0; i < 6; i++) rnd_pix(0, 0, 1);

        // Overflow: 18 pixels into a stalled FIFO, then drain while still streaming.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) rnd_pix(0, 1, 0);
        check("ovf_level", int'(bus.fifo_level), D);
        check("ovf_flag", int'(bus.overflow), 1);
        for (int i = 0; i < 3; i++) rnd_pix(0, 1, 1);
        for (int i = 0; i < 20; i++) rnd_pix(0, 0, 1);

        // Full FIFO with simultaneous push and pop must not drop.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < D; i++) rnd_pix(0, 1, 0);
        for (int i = 0; i < 4; i++) rnd_pix(0, 1, 1);
        check("full_pp_level", int'(bus.fifo_level), D);
        check("full_pp_ovf", int'(bus.overflow), 0);
        for (int i = 0; i < 20; i++) rnd_pix(0, 0, 1);

        // Frame wrap with continuous writes.
        cycle(1, 0, 1, 0, 0, 0);
        for (int i = 0; i < FRAME + 8; i++) rnd_pix(0, 1, 1);
        for (int i = 0; i < 4; i++) rnd_pix(0, 0, 1);

        // frame_start with a pixel while entries are queued and overflow is set.
        for (int i = 0; i < D + 2; i++) rnd_pix(0, 1, 0);
        for (int i = 0; i < D - 5; i++) rnd_pix(0, 0, 1);
        check("pre_fs_level", int'(bus.fifo_level), 5);
        rnd_pix(1, 1, 0);
        check("fs_level", int'(bus.fifo_level), 1);
        check("fs_ovf", int'(bus.overflow), 0);
        check("fs_addr", int'(bus.mem_addr), 0);
        rnd_pix(0, 1, 1);
        for (int i = 0; i < 4; i++) rnd_pix(0, 0, 1);

        // Random traffic with varying memory throughput.
        for (int blk = 0; blk < 40; blk++) begin
            rdy_pct = int'($urandom_range(0, 100));
            for (int i = 0; i < 64; i++) begin
                rnd_pix(($urandom_range(0, 199) == 0) ? 1 : 0,
                        ($urandom_range(0, 9) < 7) ? 1 : 0,
                        (int'($urandom_range(0, 99)) < rdy_pct) ? 1 : 0);
            end
        end

        // Asynchronous reset in the middle of traffic discards everything.
        for (int i = 0; i < 10; i++) rnd_pix(0, 1, 0);
        do_reset();
        for (int i = 0; i < 3; i++) rnd_pix(0, 0, 1);
        for (int i = 0; i < 200; i++) rnd_pix(0, ($urandom_range(0, 1) == 1) ? 1 : 0,
                                              ($urandom_range(0, 1) == 1) ? 1 : 0);
        for (int i = 0; i < 20; i++) rnd_pix(0, 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_write_stage.md
Name: fb_write_stage

Overview:
Consumes the serial RGB888 pixel stream from pixel_pipeline (R, G, B, valid_pix). Converts each pixel to RGB565 and assigns it a linear framebuffer address in raster order. Buffers pixels in a small first-word-fall-through (FWFT) FIFO, because pixel_pipeline has no backpressure. Drains the FIFO to the framebuffer memory port under a valid/ready handshake, and reports end-of-frame and overflow.

Parameters:
H_RES, 320, pixels per line
V_RES, 240, lines per frame
FIFO_DEPTH, 16, FIFO entries; must be a power of 2 and at least 2
ADDR_W, 17, framebuffer word address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; restarts addressing at pixel 0 and flushes the FIFO
R  in  8  red, from pixel_pipeline
G  in  8  green, from pixel_pipeline
B  in  8  blue, from pixel_pipeline
valid_pix  in  1  pixel present this cycle
mem_addr  out  ADDR_W  framebuffer word address (FIFO head)
mem_data  out  16  RGB565 pixel (FIFO head)
mem_we  out  1  write request; equals FIFO not-empty
mem_ready  in  1  memory accepts the write this cycle
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: at least one pixel dropped since the last clear
frame_done  out  1  one-cycle pulse: last pixel of the frame written to memory

Behaviour:
- Reset (rst_n low, async): FIFO empty, write pointer, read pointer, level, pixel address counter, overflow and frame_done all 0. Hence mem_we=0, mem_addr=0, mem_data=0.
- RGB565 conversion: {R[7:3], G[7:2], B[7:3]}. Pure truncation, no rounding.
- Address counter pix_addr:
  - Increments by 1 on every cycle with valid_pix=1, whether or not the pixel is stored.
  - Wraps from H_RES*V_RES-1 to 0.
  - The pushed entry is {pix_addr, rgb565} as seen before the increment.
- Push: valid_pix=1 and (FIFO not full, or a pop occurs in the same cycle).
- Pop: mem_we && mem_ready.
- Transfer: a write completes on any rising edge where mem_we=1 and mem_ready=1.
- FIFO head is combinational (FWFT):
  - mem_we = !empty; mem_addr and mem_data are the head entry.
  - While mem_we=1 and mem_ready=0, mem_addr and mem_data hold stable.
  - When empty, mem_addr and mem_data hold their last values; both are 0 after reset.
- Latency: a pixel pushed into an empty FIFO at edge N is presented on mem_* in the cycle after edge N. Each accepted pixel produces exactly one write.
- fifo_level:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, including when full (FIFO_DEPTH) and when empty (1 pushed, 0 popped is impossible since mem_we=0).
- Overflow:
  - Triggered by valid_pix=1 with the FIFO full and no pop that cycle.
  - The pixel is dropped and overflow is set, staying high until frame_start or reset.
  - pix_addr still advances, so later pixels keep their correct addresses.
- frame_done: registered. It is 1 for exactly one cycle after an edge that popped the entry with address H_RES*V_RES-1; otherwise 0.
- frame_start (synchronous, highest priority):
  - Flushes the FIFO: pointers and level go to 0 and no pop is counted that cycle, so mem_we=0 next cycle.
  - Clears overflow and frame_done.
  - If valid_pix is also 1, that pixel is pushed at address 0 into the freshly emptied FIFO and pix_addr becomes 1. Otherwise pix_addr becomes 0.
- Reset mid-operation: all state is lost immediately; any in-flight FIFO contents are discarded and no further writes are issued.
- Internal pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.

Test Plan:
- Reset then a single pixel (R=0xFF, G=0x80, B=0x08, valid_pix one cycle, mem_ready=1): exactly one write with mem_addr=0 and mem_data=0xFC01, mem_we high for exactly one cycle starting one cycle after the input edge; fifo_level returns to 0.
- Quad stream (4 consecutive valid_pix cycles, mem_ready=0 for 6 cycles then 1): fifo_level climbs 1..4 and holds at 4. The head stays at addr 0 while stalled, then drains addresses 0,1,2,3 on consecutive cycles; overflow stays 0.
- Overflow (FIFO_DEPTH=16, mem_ready=0, 18 pixels): fifo_level=16 and overflow=1 after the 17th pixel. Then raise mem_ready: 16 writes with addresses 0..15, and the 19th pixel written at address 18.
- Full with simultaneous push/pop (FIFO full, valid_pix=1 and mem_ready=1 on the same cycle): no drop, overflow stays 0, fifo_level stays 16.
- Frame wrap (H_RES=4, V_RES=2, 9 pixels, mem_ready=1): addresses 0..7 then 0. frame_done pulses once, in the cycle after the edge that writes address 7.
- frame_start (pulsed mid-stream with valid_pix=1 and 5 entries queued, overflow=1): fifo_level becomes 1 and overflow becomes 0. The next write is mem_addr=0 with that cycle's pixel data, followed by address 1.
